// File: rtl/uram_burst_reader.sv
// rtl/uram_burst_reader.sv - burst read engine feeding one UltraRAM read port
// Issues single-beat reads under a credit limit and returns words through a FWFT FIFO.
module uram_burst_reader #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 72,
  parameter int NBPIPE     = 3,
  parameter int LWIDTH     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
);

  localparam int LAT = NBPIPE + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [LWIDTH-1:0] remaining, remaining_nxt;
  logic              issue;
  logic              credit_ok;

  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     outstanding;
  logic [LAT-1:0]    trk_valid;
  logic [LAT-1:0]    trk_last;

  logic              push;
  logic              pop;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;

  // Credits cover both reads still in the RAM pipeline and words parked in the FIFO.
  assign outstanding = inflight + fifo_count;
  assign credit_ok   = outstanding < DEPTH_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    issue         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt     = ISSUE;
          cur_addr_nxt  = req_addr;
          remaining_nxt = req_len;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue         = 1'b1;
          cur_addr_nxt  = cur_addr + AWIDTH'(1);
          remaining_nxt = remaining - LWIDTH'(1);
          if (remaining == '0) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = cur_addr;

  // The tail of the tracker lines up with the cycle the RAM presents the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_valid <= '0;
      trk_last  <= '0;
      inflight  <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_last[i]  <= trk_last[i-1];
      end
      trk_valid[0] <= issue;
      trk_last[0]  <= issue && (remaining == '0);
      inflight     <= inflight + CW'(issue) - CW'(push);
    end
  end

  assign push = trk_valid[LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_dout;
      fifo_last[wr_ptr] <= trk_last[LAT-1];
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = fifo_data[rd_ptr];
  assign rsp_last  = rsp_valid && fifo_last[rd_ptr];
  assign busy      = (state == ISSUE) || (inflight != '0) || rsp_valid;

endmodule

// File: tb/tb_uram_burst_reader.sv
// tb/tb_uram_burst_reader.sv - self-checking bench for uram_burst_reader
// Table of bursts with a response scoreboard, plus timing, backpressure and reset sequences.
module tb_uram_burst_reader;

  localparam int AWIDTH     = 12;
  localparam int DWIDTH     = 72;
  localparam int NBPIPE     = 3;
  localparam int LWIDTH     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int LAT        = NBPIPE + 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_addr;
  logic [LWIDTH-1:0] req_len;
  logic              ram_en;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  uram_burst_reader #(
    .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NBPIPE(NBPIPE),
    .LWIDTH(LWIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DWIDTH-1:0] ram_word(input logic [AWIDTH-1:0] a);
    return DWIDTH'(a);
  endfunction

  // RAM model: mem[a] = a, LAT cycles from enable to data, never reset.
  logic [DWIDTH-1:0] ram_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
    ram_pipe[0] <= ram_en ? ram_word(ram_addr) : {DWIDTH{1'b1}};
  end
  assign ram_dout = ram_pipe[LAT-1];

  typedef struct {
    logic [DWIDTH-1:0] data;
    logic              last;
  } exp_t;

  typedef struct {
    logic [AWIDTH-1:0] addr;
    logic [LWIDTH-1:0] len;
    int                mode;
    bit                fresh;
    bit                wait_done;
    int                exp_beats;
    int                exp_lasts;
    logic [AWIDTH-1:0] exp_first;
    logic [AWIDTH-1:0] exp_last;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [AWIDTH-1:0] issued[$];
  vec_t tbl[7];

  int vectors = 0;
  int miscompares = 0;
  int beats_seen, lasts_seen;
  logic [DWIDTH-1:0] first_seen, last_seen;
  int en_total, en_run, en_max, v_run, v_max;
  int rr_viol = 0, we_seen = 0, overflow = 0;
  bit rand_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AWIDTH-1:0] a, input logic [LWIDTH-1:0] l,
                              input int m, input bit f, input bit w, input int eb,
                              input int el, input logic [AWIDTH-1:0] ef,
                              input logic [AWIDTH-1:0] ela);
    vec_t v;
    v.addr = a; v.len = l; v.mode = m; v.fresh = f; v.wait_done = w;
    v.exp_beats = eb; v.exp_lasts = el; v.exp_first = ef; v.exp_last = ela;
    return v;
  endfunction

  task automatic clear_stats();
    beats_seen = 0; lasts_seen = 0; first_seen = '0; last_seen = '0;
    en_total = 0; en_run = 0; en_max = 0; v_run = 0; v_max = 0;
    issued.delete();
  endtask

  // Scoreboard consumer: every accepted beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_last", rsp_last, mon_e.last);
      end
      if (beats_seen == 0) first_seen = rsp_data;
      if (rsp_last) begin
        last_seen = rsp_data;
        lasts_seen++;
      end
      beats_seen++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (ram_en) begin
        en_total++;
        issued.push_back(ram_addr);
        en_run++;
        if (en_run > en_max) en_max = en_run;
        if (req_ready) rr_viol++;
      end else begin
        en_run = 0;
      end
      if (rsp_valid) begin
        v_run++;
        if (v_run > v_max) v_max = v_run;
      end else begin
        v_run = 0;
      end
      if (ram_we) we_seen++;
      if (dut.push && dut.fifo_count == FIFO_DEPTH) overflow++;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_req(input logic [AWIDTH-1:0] a, input logic [LWIDTH-1:0] l);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i <= int'(l); i++) begin
      exp_t e;
      e.data = ram_word(a + AWIDTH'(i));
      e.last = (i == int'(l));
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 4000);
    if (!req_ready) check("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 4000);
    if (busy || sb.size() != 0) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_last"}, rsp_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [8:0] en_m, v_m, b_m;
    int rv;

    //            addr     len  mode fresh wait beats lasts first    last
    tbl[0] = mk(12'h010, 8'd0,   0, 1, 1,   1,  1, 12'h010, 12'h010);
    tbl[1] = mk(12'h100, 8'd15,  1, 1, 1,  16,  1, 12'h100, 12'h10F);
    tbl[2] = mk(12'hFFE, 8'd3,   2, 1, 1,   4,  1, 12'hFFE, 12'h001);
    tbl[3] = mk(12'h200, 8'd31,  3, 1, 1,  32,  1, 12'h200, 12'h21F);
    tbl[4] = mk(12'h300, 8'd0,   4, 1, 0,   0,  0, 12'h000, 12'h000);
    tbl[5] = mk(12'h400, 8'd5,   4, 0, 0,   0,  0, 12'h000, 12'h000);
    tbl[6] = mk(12'h500, 8'd255, 4, 0, 1, 263,  3, 12'h300, 12'h5FF);

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk);
    #1 rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      if (tbl[k].fresh) clear_stats();
      if (tbl[k].mode == 3) begin
        rand_mode = 1'b0; rsp_ready = 1'b0;
      end else if (tbl[k].mode == 4) begin
        rand_mode = 1'b1;
      end else begin
        rand_mode = 1'b0; rsp_ready = 1'b1;
      end

      send_req(tbl[k].addr, tbl[k].len);

      if (tbl[k].mode == 0) begin
        en_m = '0; v_m = '0; b_m = '0;
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          en_m[c] = ram_en; v_m[c] = rsp_valid; b_m[c] = busy;
        end
        check("single_ram_en_cycles", en_m, 9'b000000010);
        check("single_rsp_valid_cycles", v_m, 9'b001000000);
        check("single_busy_cycles", b_m, 9'b001111110);
      end else if (tbl[k].mode == 3) begin
        repeat (20) @(negedge clk);
        check("bp_issues_while_stalled", en_total, FIFO_DEPTH);
        rsp_ready = 1'b1;
      end

      if (tbl[k].wait_done) begin
        wait_idle();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        check("burst_beats", beats_seen, tbl[k].exp_beats);
        check("burst_issues", en_total, tbl[k].exp_beats);
        check("burst_lasts", lasts_seen, tbl[k].exp_lasts);
        check("burst_first_data", first_seen, ram_word(tbl[k].exp_first));
        check("burst_last_data", last_seen, ram_word(tbl[k].exp_last));
        if (tbl[k].mode == 1) begin
          check("fullrate_ram_en_run", en_max, 16);
          check("fullrate_rsp_valid_run", v_max, 16);
        end
        if (tbl[k].mode == 2) begin
          check("wrap_issue_count", issued.size(), 4);
          if (issued.size() == 4) begin
            check("wrap_addr0", issued[0], 12'hFFE);
            check("wrap_addr1", issued[1], 12'hFFF);
            check("wrap_addr2", issued[2], 12'h000);
            check("wrap_addr3", issued[3], 12'h001);
          end
        end
      end
    end

    // Reset two cycles after the first issue of a len=7 burst.
    clear_stats();
    rsp_ready = 1'b1;
    send_req(12'h600, 8'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    check("rst_ram_en_immediate", ram_en, 0);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    rv = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    check("post_reset_rsp_valid", rv, 0);
    check("post_reset_busy", busy, 0);

    clear_stats();
    send_req(12'h700, 8'd4);
    wait_idle();
    check("after_rst_beats", beats_seen, 5);
    check("after_rst_issues", en_total, 5);
    check("after_rst_lasts", lasts_seen, 1);
    check("after_rst_first", first_seen, ram_word(12'h700));
    check("after_rst_last", last_seen, ram_word(12'h704));

    check("fifo_overflow_pushes", overflow, 0);
    check("ram_we_high_cycles", we_seen, 0);
    check("req_ready_during_issue", rr_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uram_burst_reader.md
# uram_burst_reader

Burst read engine that sits directly upstream of one UltraRAM read port. It accepts a (start address, length) request, issues back-to-back single-beat reads to the RAM, and tracks the RAM's fixed pipeline latency. Returned words are captured into a credit-protected output FIFO and presented as a valid/ready stream with a last-beat flag. Consumers are the scan/filter stages, which may apply backpressure at any time.

## Interface

- AWIDTH, 12, RAM address width (matches the RAM instance)
- DWIDTH, 72, data width
- NBPIPE, 3, RAM output pipeline registers; read latency LAT = NBPIPE+1
- LWIDTH, 8, burst length field width
- FIFO_DEPTH, 8, output FIFO entries; power of 2, must be ≥ NBPIPE+3 for 1 beat/cycle

Ports:

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  AWIDTH  first beat address
- req_len  in  LWIDTH  beats minus 1 (0 = 1 beat, max 2^LWIDTH beats)
- ram_en  out  1  RAM memory enable (one read per high cycle)
- ram_we  out  1  RAM write enable, constant 0
- ram_addr  out  AWIDTH  RAM address
- ram_dout  in  DWIDTH  RAM data output
- rsp_valid  out  1  output word valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  DWIDTH  output word
- rsp_last  out  1  final beat of the burst
- busy  out  1  burst issuing, or reads in flight, or FIFO non-empty

## Operation

- FSM states: IDLE, ISSUE. req_ready = (state==IDLE).
- IDLE: on handshake, latch cur_addr=req_addr and remaining=req_len, then go to ISSUE.
- ISSUE: issue a read when credits are available (outstanding < FIFO_DEPTH). outstanding = in-flight reads + FIFO occupancy, counted from registered state.
  - Issue sets ram_en=1 and ram_addr=cur_addr, then cur_addr+1 (wraps mod 2^AWIDTH) and remaining-1.
  - Issue with remaining==0 is the last beat; state returns to IDLE next cycle.
  - No issue leaves ram_en=0 and state unchanged.
- In-flight tracker: LAT-deep shift register of {valid, last}, advancing every cycle.
  - The tail entry pushes {ram_dout, last} into the FIFO on the following edge.
  - The push happens exactly LAT cycles after the issue cycle.
- FIFO is first-word fall-through: rsp_valid = !empty, and rsp_data/rsp_last come from the head entry. Pop on rsp_valid && rsp_ready.
- Push and pop in the same cycle are both performed. The credit rule guarantees that a push never finds the FIFO full; the bench asserts this.
- ram_we is never driven high.
- Reset values: FSM IDLE, req_ready=1, ram_en=0, ram_we=0, ram_addr=0, rsp_valid=0, rsp_last=0, busy=0. FIFO pointers, counts and tracker all clear. rsp_data is don't-care while rsp_valid=0.
- Reset mid-burst: issuing stops immediately and the tracker is cleared. Words the RAM pipeline still returns after reset are discarded, and no stale rsp_valid is produced.

## Timing

- Request accepted at edge e: first ram_en=1 in the cycle after e.
- Read issued in cycle t: word at ram_dout in cycle t+LAT, captured at the end of that cycle, rsp_valid in cycle t+LAT+1. With NBPIPE=3, issue at cycle 0 gives rsp_valid at cycle 5.
- With rsp_ready held at 1 and FIFO_DEPTH ≥ NBPIPE+3: one ram_en per cycle, and rsp_valid stays continuous once the first word arrives.
- Backpressure: issue stalls once outstanding reaches FIFO_DEPTH. It resumes one cycle after the pop that frees a credit.
- Back-to-back bursts: minimum one IDLE cycle between the last issue of one burst and the first issue of the next.
- rsp_last is high only on the beat whose issue had remaining==0.
- busy drops in the cycle after the last word is popped.

## Test plan

- Single beat: req_addr=0x010, req_len=0, rsp_ready=1, RAM preloaded with mem[a]=a. Expect exactly one ram_en, in cycle 1; rsp_valid, rsp_data=0x010 and rsp_last=1 in cycle 6; busy low from cycle 7.
- Full-rate burst: addr=0x100, len=15, rsp_ready=1. Expect 16 consecutive ram_en cycles, 16 consecutive rsp beats with data 0x100..0x10F, and rsp_last only on 0x10F.
- Address wrap: addr=0xFFE, len=3. Expect ram_addr sequence FFE, FFF, 000, 001, with data in the same order.
- Backpressure: len=31, rsp_ready=0 for 20 cycles, then 1. Expect issues to stop after 8 outstanding and no FIFO overflow. All 32 words arrive in order with none lost or duplicated.
- Random rsp_ready (50%), three back-to-back bursts of lengths 0, 5 and 255. Expect all data in order, one rsp_last per burst, and req_ready low during ISSUE.
- Reset asserted 2 cycles after the first issue of a len=7 burst, released 1 cycle later. Expect all outputs at reset values, and no rsp_valid for 10 cycles afterwards despite RAM pipeline returns. A subsequent burst then completes correctly.
